// File: rtl/quick_uart_tx_arbiter.sv
// quick_uart_tx_arbiter
//
// Round-robin arbiter sharing one quick_uart_tx byte interface among NUM_REQ
// ready/valid requesters. A grant is held for a whole packet: it is released
// on the accepted beat flagged last, or after MAX_BURST accepted beats
// (MAX_BURST = 0 disables the burst limit). The beat toward the UART is held
// in a single output register that drains independently of the grant state.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_valid_i  per-requester valid
//   req_ready_o  per-requester ready (only the granted requester can see 1)
//   req_data_i   requester n occupies bits [n*DATA_BITS +: DATA_BITS]
//   req_last_i   per-requester end-of-packet flag
//   tx_valid_o   beat available to the UART TX (registered)
//   tx_ready_i   UART TX accepts the beat
//   tx_data_o    beat data (registered)
//   grant_o      one-hot current owner, zero while idle (registered)
//   busy_o       high while a grant is held or a beat is buffered
module quick_uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic [DATA_BITS-1:0]         tx_data_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    // Counter value of the final beat of a burst (counter + 1 == MAX_BURST).
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic                 out_free;
    logic                 accept;
    logic                 burst_hit;
    logic                 release_pkt;
    logic [DATA_BITS-1:0] sel_data;
    logic                 sel_last;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;

    // The output register can take a new beat when empty or draining now.
    assign out_free    = ~tx_valid_o | tx_ready_i;
    assign req_ready_o = ((state == GRANT) && out_free) ? grant_o : '0;
    assign accept      = |(req_valid_i & req_ready_o);
    assign busy_o      = (state == GRANT) | tx_valid_o;

    assign burst_hit   = (MAX_BURST != 0) && (beat_cnt == BURST_LAST);
    assign release_pkt = accept & (sel_last | burst_hit);

    // Data/last mux driven by the one-hot grant; non-granted lanes are ignored.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant_o[n]) begin
                sel_data = req_data_i[n*DATA_BITS +: DATA_BITS];
                sel_last = req_last_i[n];
            end
        end
    end

    // Round-robin search starting at ptr+1. Offsets are scanned from the
    // farthest down to the nearest so the nearest valid requester wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        cand       = 0;
        cidx       = '0;
        pick_found = 1'b0;
        pick_idx   = ptr;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = cand[IDX_W-1:0];
            if (req_valid_i[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            grant_o    <= '0;
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            // A load wins over a drain, giving back-to-back beats.
            if (accept) begin
                tx_data_o  <= sel_data;
                tx_valid_o <= 1'b1;
            end else if (tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_o  <= NUM_REQ'(1) << pick_idx;
                        ptr      <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    if (release_pkt) begin
                        grant_o <= '0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    grant_o <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quick_uart_tx_arbiter.sv
// Testbench for quick_uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8, MAX_BURST=4).
// Requester beats are queued in a pending list that a driver presents on the
// request lanes; expected UART beats and expected grant order are pushed into
// scoreboard queues and a negedge monitor pops and compares them.
module tb_quick_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int MB = 4;

    typedef struct packed {
        logic [3:0] req;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*DB-1:0] req_data = '0;
    logic [NR-1:0]    req_last = '0;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic [DB-1:0]    tx_data;
    logic [NR-1:0]    grant;
    logic             busy;

    beat_t      pend[$];
    logic [7:0] exp_data[$];
    logic [3:0] exp_grant[$];
    logic [NR-1:0] hold = '0;

    int         n_cmp = 0;
    int         n_fail = 0;
    bit         tight = 1'b0;
    int         phase_grants = 0;
    int         idle_run = 0;
    logic [3:0] prev_grant = '0;

    quick_uart_tx_arbiter #(
        .NUM_REQ  (NR),
        .DATA_BITS(DB),
        .MAX_BURST(MB)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find_front(input int r);
        for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].req == 4'(r)) return k;
        end
        return -1;
    endfunction

    task automatic add_beat(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b.req  = 4'(r);
        b.last = l;
        b.data = d;
        pend.push_back(b);
    endtask

    // Driver: each requester presents its oldest pending beat after the edge.
    always @(posedge clk) begin
        int k;
        #1;
        for (int n = 0; n < NR; n++) begin
            k = find_front(n);
            if (k >= 0 && !hold[n]) begin
                req_valid[n]          = 1'b1;
                req_data[n*DB +: DB]  = pend[k].data;
                req_last[n]           = pend[k].last;
            end else begin
                req_valid[n] = 1'b0;
                req_last[n]  = 1'b0;
            end
        end
    end

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        int k;
        if (!rst_n) begin
            prev_grant = '0;
            idle_run   = 0;
        end else begin
            for (int n = 0; n < NR; n++) begin
                if (req_valid[n] && req_ready[n]) begin
                    k = find_front(n);
                    if (k >= 0) pend.delete(k);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_beat: got 0x%0h, expected no beat (t=%0t)", tx_data, $time);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(exp_data.pop_front()));
                end
            end
            if (grant != '0 && grant != prev_grant) begin
                if (prev_grant != '0) begin
                    check("grant_gap", 32'(prev_grant), 32'(0));
                end else if (tight && phase_grants > 0) begin
                    check("idle_gap", 32'(idle_run), 32'(1));
                end
                if (exp_grant.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_grant: got 0x%0h, expected no grant (t=%0t)", grant, $time);
                end else begin
                    check("grant_order", 32'(grant), 32'(exp_grant.pop_front()));
                end
                phase_grants++;
            end
            if (grant == '0) idle_run++;
            else idle_run = 0;
            prev_grant = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        pend.delete();
        exp_data.delete();
        exp_grant.delete();
        hold = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        flush();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && (exp_data.size() != 0 || exp_grant.size() != 0); i++) begin
            @(negedge clk);
        end
        check(name, 32'(exp_data.size() + exp_grant.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        tick();
        rst_n = 1'b1;

        // Single packet from requester 2
        @(negedge clk);
        add_beat(2, 8'h41, 1'b0);
        add_beat(2, 8'h42, 1'b0);
        add_beat(2, 8'h43, 1'b1);
        exp_data.push_back(8'h41);
        exp_data.push_back(8'h42);
        exp_data.push_back(8'h43);
        exp_grant.push_back(4'b0100);
        @(negedge clk);
        check("sp_idle_grant", 32'(grant), 32'(0));
        check("sp_idle_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        check("sp_grant", 32'(grant), 32'(4'b0100));
        check("sp_ready", 32'(req_ready), 32'(4'b0100));
        check("sp_busy", 32'(busy), 32'(1));
        check("sp_empty", 32'(tx_valid), 32'(0));
        @(negedge clk);
        check("sp_valid_b0", 32'(tx_valid), 32'(1));
        check("sp_data_b0", 32'(tx_data), 32'(8'h41));
        @(negedge clk);
        check("sp_data_b1", 32'(tx_data), 32'(8'h42));
        @(negedge clk);
        check("sp_data_b2", 32'(tx_data), 32'(8'h43));
        check("sp_release", 32'(grant), 32'(0));
        check("sp_rel_ready", 32'(req_ready), 32'(0));
        check("sp_rel_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("sp_drained", 32'(tx_valid), 32'(0));
        check("sp_idle_busy", 32'(busy), 32'(0));
        wait_drain("drain_single", 20);

        // Round-robin among requesters 0, 1 and 3
        do_reset();
        tight = 1'b1;
        phase_grants = 0;
        @(negedge clk);
        add_beat(0, 8'h00, 1'b1);
        add_beat(0, 8'h01, 1'b1);
        add_beat(1, 8'h10, 1'b1);
        add_beat(1, 8'h11, 1'b1);
        add_beat(3, 8'h30, 1'b1);
        add_beat(3, 8'h31, 1'b1);
        exp_data = '{8'h00, 8'h10, 8'h30, 8'h01, 8'h11, 8'h31};
        exp_grant = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        wait_drain("drain_rr", 60);
        tight = 1'b0;

        // Burst limit: requester 1 streams without last, requester 0 joins
        do_reset();
        tight = 1'b1;
        phase_grants = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) add_beat(1, 8'(8'h80 + i), 1'b0);
        exp_data = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h05, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89};
        exp_grant = '{4'b0010, 4'b0001, 4'b0010, 4'b0010};
        @(negedge clk);
        add_beat(0, 8'h05, 1'b1);
        wait_drain("drain_burst", 80);
        @(negedge clk);
        check("burst_hold", 32'(grant), 32'(4'b0010));
        tight = 1'b0;

        // Backpressure during a 3-beat packet
        do_reset();
        @(negedge clk);
        add_beat(2, 8'hA1, 1'b0);
        add_beat(2, 8'hA2, 1'b0);
        add_beat(2, 8'hA3, 1'b1);
        exp_data = '{8'hA1, 8'hA2, 8'hA3};
        exp_grant = '{4'b0100};
        @(negedge clk);
        @(negedge clk);
        check("bp_ready_empty", 32'(req_ready), 32'(4'b0100));
        @(negedge clk);
        check("bp_data_a1", 32'(tx_data), 32'(8'hA1));
        check("bp_ready_drain", 32'(req_ready), 32'(4'b0100));
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_stall0", 32'(req_ready), 32'(0));
        check("bp_valid_stall0", 32'(tx_valid), 32'(1));
        check("bp_data_stall0", 32'(tx_data), 32'(8'hA2));
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_stall1", 32'(req_ready), 32'(0));
        check("bp_data_stall1", 32'(tx_data), 32'(8'hA2));
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_resume", 32'(req_ready), 32'(4'b0100));
        check("bp_data_resume", 32'(tx_data), 32'(8'hA2));
        @(negedge clk);
        check("bp_data_a3", 32'(tx_data), 32'(8'hA3));
        check("bp_release", 32'(grant), 32'(0));
        @(negedge clk);
        check("bp_drained", 32'(tx_valid), 32'(0));
        wait_drain("drain_bp", 20);

        // Mid-packet stall of the granted requester
        do_reset();
        @(negedge clk);
        add_beat(0, 8'hC0, 1'b0);
        add_beat(0, 8'hC1, 1'b0);
        add_beat(0, 8'hC2, 1'b1);
        add_beat(3, 8'hD0, 1'b1);
        add_beat(1, 8'hE0, 1'b1);
        exp_data = '{8'hC0, 8'hC1, 8'hC2, 8'hE0, 8'hD0};
        exp_grant = '{4'b0001, 4'b0010, 4'b1000};
        @(negedge clk);
        @(negedge clk);
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 32'(grant), 32'(4'b0001));
        end
        hold[0] = 1'b0;
        wait_drain("drain_stall", 40);

        // Asynchronous reset mid-packet, then requester 0 priority
        @(negedge clk);
        add_beat(1, 8'h61, 1'b0);
        add_beat(1, 8'h62, 1'b0);
        add_beat(1, 8'h63, 1'b1);
        exp_data = '{8'h61, 8'h62, 8'h63};
        exp_grant = '{4'b0010};
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        flush();
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'(0));
        check("async_tx_data", 32'(tx_data), 32'(0));
        check("async_grant", 32'(grant), 32'(0));
        check("async_req_ready", 32'(req_ready), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        add_beat(2, 8'h71, 1'b1);
        add_beat(0, 8'h01, 1'b1);
        exp_data = '{8'h01, 8'h71};
        exp_grant = '{4'b0001, 4'b0100};
        @(negedge clk);
        @(negedge clk);
        check("prio_after_reset", 32'(grant), 32'(4'b0001));
        wait_drain("drain_prio", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
